// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: one parallel command to one CPOL=0/CPHA=1 frame
//
// Frame: csn low, SETUP_CYC idle cycles, command byte, address byte, 1..256
// data bytes, CLK_DIV hold cycles, csn high for GAP_CYC cycles.
// Each bit is CLK_DIV cycles SCK low, rising edge (MOSI updates), CLK_DIV
// cycles SCK high, falling edge (both sides sample).
//
// Ports:
//   clk_i, rst_n            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake (ready only in IDLE)
//   cmd_wr_i                1 = write (0x80), 0 = read (0x08)
//   cmd_addr_i, cmd_len_i   start address, data byte count minus one
//   cmd_clr_i               clear command (0x55 only), with SPI_MASTER_CLR_EN
//   wr_data_i/_valid_i      write data source
//   wr_data_ready_o         pulse: wr_data_i is consumed this cycle
//   rd_data_o, rd_valid_o   received data byte and its one-cycle strobe
//   busy_o, done_o          not idle / end-of-frame pulse at csn rise
//   spi_csn_o, spi_clk_o, spi_mosi_o, spi_miso_i   SPI bus
//
// Optional feature macro: SPI_MASTER_CLR_EN

module spi_master_ctrl #(
    parameter int CLK_DIV   = 8,
    parameter int SETUP_CYC = 8,
    parameter int GAP_CYC   = 16
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_wr_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_len_i,
`ifdef SPI_MASTER_CLR_EN
    input  logic       cmd_clr_i,
`endif
    input  logic [7:0] wr_data_i,
    input  logic       wr_data_valid_i,
    output logic       wr_data_ready_o,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       spi_csn_o,
    output logic       spi_clk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  rx_q, rx_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
`ifdef SPI_MASTER_CLR_EN
    logic        clr_q, clr_d;
`endif
    logic        csn_q, csn_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        done_q, done_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_pend_q, rd_pend_d;
    logic        ready_q, ready_d;
    logic        load_pend_q, load_pend_d;
    logic        miso_s1_q, miso_s1_d;
    logic        miso_s2_q, miso_s2_d;

    logic        byte_done;
    logic        load_data;
    logic [7:0]  cmd_byte;

    always_comb begin
        cmd_byte = wr_q ? 8'h80 : 8'h08;
`ifdef SPI_MASTER_CLR_EN
        if (clr_q) begin
            cmd_byte = 8'h55;
        end
`endif
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_cnt_d       = bit_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        sr_d            = sr_q;
        rx_d            = rx_q;
        wr_d            = wr_q;
        addr_d          = addr_q;
        len_d           = len_q;
`ifdef SPI_MASTER_CLR_EN
        clr_d           = clr_q;
`endif
        csn_d           = csn_q;
        sck_d           = sck_q;
        mosi_d          = mosi_q;
        done_d          = 1'b0;
        rd_data_d       = rd_data_q;
        rd_valid_d      = 1'b0;
        rd_pend_d       = 1'b0;
        load_pend_d     = load_pend_q;
        miso_s1_d       = spi_miso_i;
        miso_s2_d       = miso_s1_q;
        wr_data_ready_o = 1'b0;
        byte_done       = 1'b0;
        load_data       = 1'b0;

        // Read bytes are published one cycle after the byte completes.
        if (rd_pend_q) begin
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                csn_d  = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                if (cmd_valid_i && ready_q) begin
                    wr_d    = cmd_wr_i;
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
`ifdef SPI_MASTER_CLR_EN
                    clr_d   = cmd_clr_i;
`endif
                    csn_d   = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d     = 16'd0;
                    bit_cnt_d = 3'd0;
                    sr_d      = cmd_byte;
                    state_d   = ST_CMD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_CMD, ST_ADDR, ST_DATA: begin
                if (load_pend_q) begin
                    // Write data stall: SCK parked low until a byte arrives.
                    load_data = 1'b1;
                end else begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d = 16'd0;
                        sck_d = ~sck_q;
                        if (!sck_q) begin
                            mosi_d = sr_q[7];
                        end else begin
                            sr_d      = {sr_q[6:0], 1'b0};
                            rx_d      = {rx_q[6:0], miso_s2_q};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            byte_done = (bit_cnt_q == 3'd7);
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end

                    if (byte_done) begin
                        case (state_q)
                            ST_CMD: begin
`ifdef SPI_MASTER_CLR_EN
                                if (clr_q) begin
                                    state_d = ST_HOLD;
                                end else begin
                                    sr_d    = addr_q;
                                    state_d = ST_ADDR;
                                end
`else
                                sr_d    = addr_q;
                                state_d = ST_ADDR;
`endif
                            end
                            ST_ADDR: begin
                                byte_cnt_d = 9'd0;
                                state_d    = ST_DATA;
                                load_data  = 1'b1;
                            end
                            default: begin
                                rd_pend_d = ~wr_q;
                                if (byte_cnt_q == {1'b0, len_q}) begin
                                    state_d = ST_HOLD;
                                end else begin
                                    byte_cnt_d = byte_cnt_q + 9'd1;
                                    load_data  = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end

            ST_HOLD: begin
                sck_d = 1'b0;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = 16'd0;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Data byte load, shared by the end of ADDR, each data byte and a stall.
        if (load_data) begin
            cnt_d     = 16'd0;
            bit_cnt_d = 3'd0;
            if (wr_q) begin
                wr_data_ready_o = wr_data_valid_i;
                if (wr_data_valid_i) begin
                    sr_d        = wr_data_i;
                    load_pend_d = 1'b0;
                end else begin
                    load_pend_d = 1'b1;
                end
            end else begin
                sr_d        = 8'h00;
                load_pend_d = 1'b0;
            end
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 9'd0;
            sr_q        <= 8'h00;
            rx_q        <= 8'h00;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            len_q       <= 8'h00;
`ifdef SPI_MASTER_CLR_EN
            clr_q       <= 1'b0;
`endif
            csn_q       <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            ready_q     <= 1'b0;
            load_pend_q <= 1'b0;
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sr_q        <= sr_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
`ifdef SPI_MASTER_CLR_EN
            clr_q       <= clr_d;
`endif
            csn_q       <= csn_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_pend_q   <= rd_pend_d;
            ready_q     <= ready_d;
            load_pend_q <= load_pend_d;
            miso_s1_q   <= miso_s1_d;
            miso_s2_q   <= miso_s2_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign spi_csn_o   = csn_q;
    assign spi_clk_o   = sck_q;
    assign spi_mosi_o  = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl with SPI slave model

module tb_spi_master_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int SETUP_CYC = 8;
    localparam int GAP_CYC   = 16;

    logic       clk_i;
    logic       rst_n;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_wr_i;
    logic [7:0] cmd_addr_i;
    logic [7:0] cmd_len_i;
    logic       cmd_clr_i;
    logic [7:0] wr_data_i;
    logic       wr_data_valid_i;
    logic       wr_data_ready_o;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       spi_csn_o;
    logic       spi_clk_o;
    logic       spi_mosi_o;
    logic       spi_miso_i;

    spi_master_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .SETUP_CYC(SETUP_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_wr_i       (cmd_wr_i),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_len_i      (cmd_len_i),
`ifdef SPI_MASTER_CLR_EN
        .cmd_clr_i      (cmd_clr_i),
`endif
        .wr_data_i      (wr_data_i),
        .wr_data_valid_i(wr_data_valid_i),
        .wr_data_ready_o(wr_data_ready_o),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .spi_csn_o      (spi_csn_o),
        .spi_clk_o      (spi_clk_o),
        .spi_mosi_o     (spi_mosi_o),
        .spi_miso_i     (spi_miso_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [7:0] s_mem   [256];
    logic [7:0] ref_mem [256];
    logic [7:0] wdata   [256];
    logic [7:0] wq[$];
    logic [7:0] rd_q[$];
    logic [7:0] fr_bytes[$];
    int         fr_low, fr_rise, fr_done, done_total, nbits, nready;
    logic [7:0] cur;
    logic       prev_sck, prev_csn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI slave model and bus monitor: drives MISO on rising SCK, samples MOSI on falling SCK.
    always @(negedge clk_i) begin : monitor
        int k;
        int b;
        logic [7:0] t;
        if (!rst_n) begin
            prev_sck   = 1'b0;
            prev_csn   = 1'b1;
            spi_miso_i = 1'b0;
        end else begin
            if (prev_csn && !spi_csn_o) begin
                fr_low  = 0;
                fr_rise = 0;
                fr_done = 0;
                nbits   = 0;
                cur     = 8'h00;
                fr_bytes.delete();
            end
            if (!spi_csn_o) fr_low++;
            if (spi_clk_o && !prev_sck) begin
                fr_rise++;
                if (fr_bytes.size() >= 2 && fr_bytes[0] == 8'h08 && nbits >= 16) begin
                    k = (nbits - 16) / 8;
                    b = 7 - (nbits % 8);
                    t = s_mem[8'(int'(fr_bytes[1]) + k)];
                    spi_miso_i = t[b];
                end else begin
                    spi_miso_i = 1'b0;
                end
            end
            if (!spi_clk_o && prev_sck) begin
                cur = {cur[6:0], spi_mosi_o};
                nbits++;
                if (nbits % 8 == 0) begin
                    if (fr_bytes.size() >= 2 && fr_bytes[0] == 8'h80)
                        s_mem[8'(int'(fr_bytes[1]) + fr_bytes.size() - 2)] = cur;
                    fr_bytes.push_back(cur);
                end
            end
            if (done_o) begin
                fr_done++;
                done_total++;
            end
            if (rd_valid_o) rd_q.push_back(rd_data_o);
            prev_sck = spi_clk_o;
            prev_csn = spi_csn_o;
        end
    end

    // Write data source: presents the head of wq, pops it when the DUT takes it.
    initial begin
        wr_data_valid_i = 1'b0;
        wr_data_i       = 8'h00;
        forever begin
            @(negedge clk_i);
            if (wq.size() > 0) begin
                wr_data_valid_i = 1'b1;
                wr_data_i       = wq[0];
            end else begin
                wr_data_valid_i = 1'b0;
                wr_data_i       = 8'($urandom);
            end
            #1;
            if (wr_data_ready_o && wr_data_valid_i && wq.size() > 0) begin
                void'(wq.pop_front());
                nready++;
            end
        end
    end

    task automatic run_frame(input logic wr, input logic [7:0] addr, input logic [7:0] len,
                             input logic clr, input logic stall, input string nm);
        int n_data, n_bytes, exp_low, t, d0;
        logic stall_ok;
        logic [7:0] exp_b[$];
        n_data  = clr ? 0 : int'(len) + 1;
        n_bytes = clr ? 1 : int'(len) + 3;
        if (clr) begin
            exp_b.push_back(8'h55);
        end else begin
            exp_b.push_back(wr ? 8'h80 : 8'h08);
            exp_b.push_back(addr);
            for (int i = 0; i < n_data; i++) exp_b.push_back(wr ? wdata[i] : 8'h00);
        end
        exp_low = SETUP_CYC + n_bytes * 16 * CLK_DIV + CLK_DIV;

        @(negedge clk_i);
        nready = 0;
        rd_q.delete();
        wq.delete();
        if (wr && !clr) begin
            if (stall) wq.push_back(wdata[0]);
            else for (int i = 0; i < n_data; i++) wq.push_back(wdata[i]);
        end
        d0 = done_total;
        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_clr_i   = clr;
        t = 0;
        while (!cmd_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        chk({nm, "_accept"}, 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_wr_i    = 1'($urandom);
        cmd_addr_i  = 8'($urandom);
        cmd_len_i   = 8'($urandom);
        cmd_clr_i   = 1'($urandom);
        chk({nm, "_csn_fall"}, 32'(spi_csn_o), 32'd0);
        chk({nm, "_busy"}, 32'(busy_o), 32'd1);

        if (stall) begin
            t = 0;
            while (wq.size() != 0 && t < 2000) begin
                @(negedge clk_i);
                t++;
            end
            repeat (140) @(negedge clk_i);
            stall_ok = 1'b1;
            repeat (500) begin
                @(negedge clk_i);
                if (spi_clk_o !== 1'b0 || spi_csn_o !== 1'b0) stall_ok = 1'b0;
            end
            chk({nm, "_stall_hold"}, 32'(stall_ok), 32'd1);
            for (int i = 1; i < n_data; i++) wq.push_back(wdata[i]);
        end

        t = 0;
        while (done_total == d0 && t < 20000) begin
            @(negedge clk_i);
            t++;
        end
        chk({nm, "_done_seen"}, 32'(done_total != d0), 32'd1);
        @(negedge clk_i);
        chk({nm, "_csn_high"}, 32'(spi_csn_o), 32'd1);
        chk({nm, "_done_once"}, 32'(fr_done), 32'd1);
        chk({nm, "_nbytes"}, 32'(fr_bytes.size()), 32'(n_bytes));
        for (int i = 0; i < n_bytes && i < fr_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), 32'(fr_bytes[i]), 32'(exp_b[i]));
        chk({nm, "_rises"}, 32'(fr_rise), 32'(8 * n_bytes));
        if (stall) chk({nm, "_low_min"}, 32'(fr_low >= exp_low + 500), 32'd1);
        else       chk({nm, "_low"}, 32'(fr_low), 32'(exp_low));
        chk({nm, "_ready_pulses"}, 32'(nready), 32'((wr && !clr) ? n_data : 0));
        chk({nm, "_rd_count"}, 32'(rd_q.size()), 32'((!wr && !clr) ? n_data : 0));
        if (!wr && !clr) begin
            for (int i = 0; i < n_data && i < rd_q.size(); i++)
                chk($sformatf("%s_rd%0d", nm, i), 32'(rd_q[i]), 32'(ref_mem[8'(int'(addr) + i)]));
        end
        if (wr && !clr) begin
            for (int i = 0; i < n_data; i++) ref_mem[8'(int'(addr) + i)] = wdata[i];
            for (int i = 0; i < n_data; i++)
                chk($sformatf("%s_mem%0d", nm, i), 32'(s_mem[8'(int'(addr) + i)]),
                    32'(ref_mem[8'(int'(addr) + i)]));
        end
    endtask

    initial begin : main
        int t, d0;
        logic [7:0] v;
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = 8'h00;
        cmd_len_i   = 8'h00;
        cmd_clr_i   = 1'b0;
        done_total  = 0;
        nready      = 0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            s_mem[i]   = v;
            ref_mem[i] = v;
        end

        repeat (3) @(negedge clk_i);
        chk("rst_csn", 32'(spi_csn_o), 32'd1);
        chk("rst_sck", 32'(spi_clk_o), 32'd0);
        chk("rst_mosi", 32'(spi_mosi_o), 32'd0);
        chk("rst_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("post_rst_ready", 32'(cmd_ready_o), 32'd1);

        wdata[0] = 8'hA5;
        run_frame(1'b1, 8'h10, 8'd0, 1'b0, 1'b0, "w1");

        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        run_frame(1'b1, 8'hFE, 8'd3, 1'b0, 1'b0, "burst");
        chk("wrap_FE", 32'(s_mem[8'hFE]), 32'h11);
        chk("wrap_FF", 32'(s_mem[8'hFF]), 32'h22);
        chk("wrap_00", 32'(s_mem[8'h00]), 32'h33);
        chk("wrap_01", 32'(s_mem[8'h01]), 32'h44);

        run_frame(1'b0, 8'hFE, 8'd1, 1'b0, 1'b0, "rd");
        if (rd_q.size() == 2) begin
            chk("rd_first", 32'(rd_q[0]), 32'h11);
            chk("rd_second", 32'(rd_q[1]), 32'h22);
        end

        for (int i = 0; i < 3; i++) wdata[i] = 8'($urandom);
        run_frame(1'b1, 8'($urandom), 8'd2, 1'b0, 1'b1, "stall");

        // Reset in the middle of the address byte.
        @(negedge clk_i);
        wq.delete();
        wq.push_back(8'h77);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = 1'b1;
        cmd_addr_i  = 8'h33;
        cmd_len_i   = 8'd0;
        t = 0;
        while (!cmd_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        d0 = done_total;
        repeat (2) @(negedge clk_i);
        t = 0;
        while (fr_rise < 12 && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        chk("abort_in_addr", 32'(fr_rise), 32'd12);
        rst_n = 1'b0;
        #1;
        chk("abort_csn", 32'(spi_csn_o), 32'd1);
        chk("abort_sck", 32'(spi_clk_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_ready", 32'(cmd_ready_o), 32'd0);
        wq.delete();
        repeat (20) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_i);
        chk("abort_no_done", 32'(done_total), 32'(d0));
        wdata[0] = 8'h5A;
        run_frame(1'b1, 8'h20, 8'd0, 1'b0, 1'b0, "post_abort");
        chk("post_abort_mem", 32'(s_mem[8'h20]), 32'h5A);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
            run_frame(1'($urandom), 8'($urandom), 8'($urandom_range(0, 4)), 1'b0, 1'b0,
                      $sformatf("rnd%0d", r));
        end

`ifdef SPI_MASTER_CLR_EN
        run_frame(1'($urandom), 8'($urandom), 8'($urandom_range(0, 4)), 1'b1, 1'b0, "clr");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
